// File: rtl/pipe_pkg.sv
// Shared types and instruction-field constants for the 5-stage 16-bit pipeline.
package pipe_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned REG_W   = 3;
  localparam int unsigned RS_LSB  = 8;
  localparam int unsigned RT_LSB  = 5;
  localparam int unsigned TMO_W   = 8;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_MEM_WAIT = 2'd2,
    HZ_HALTED   = 2'd3
  } hz_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use compare: a load in EX whose destination is a source of the ID instruction.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [INSTR_W-1:0] ID_Instr,
  input  logic               ID_uses_rs,
  input  logic               ID_uses_rt,
  input  logic               IE_memRead,
  input  logic               IE_regWrite,
  input  logic [REG_W-1:0]   IE_writereg,
  output logic               lu_hazard
);

  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic             unused_bits;

  assign rs          = ID_Instr[RS_LSB +: REG_W];
  assign rt          = ID_Instr[RT_LSB +: REG_W];
  assign unused_bits = ^{ID_Instr[INSTR_W-1:RS_LSB+REG_W], ID_Instr[RT_LSB-1:0]};

  assign lu_hazard = IE_memRead & IE_regWrite &
                     ((ID_uses_rs & (IE_writereg == rs)) |
                      (ID_uses_rt & (IE_writereg == rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubbles, cache-miss freezes, branch squash, HALT latch.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] ID_Instr,
  input  logic               ID_uses_rs,
  input  logic               ID_uses_rt,
  input  logic               IE_memRead,
  input  logic               IE_regWrite,
  input  logic [REG_W-1:0]   IE_writereg,
  input  logic               IE_branch_taken,
  input  logic               imem_stall,
  input  logic               dmem_stall,
  input  logic               WB_halt,
  output logic               pc_we,
  output logic               ifid_we,
  output logic               ifid_flush,
  output logic               idex_we,
  output logic               idex_bubble,
  output logic               exmem_we,
  output logic               memwb_we,
  output logic               halted,
  output logic               err,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  hz_state_e        state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             lu_hazard;

  hazard_detect u_hazard_detect (
    .ID_Instr    (ID_Instr),
    .ID_uses_rs  (ID_uses_rs),
    .ID_uses_rt  (ID_uses_rt),
    .IE_memRead  (IE_memRead),
    .IE_regWrite (IE_regWrite),
    .IE_writereg (IE_writereg),
    .lu_hazard   (lu_hazard)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= HZ_RUN;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      if (!pc_we && (state_q != HZ_HALTED) && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Next state and Mealy stage controls; everything frozen unless a rule opens it.
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_we     = 1'b0;
    idex_bubble = 1'b0;
    exmem_we    = 1'b0;
    memwb_we    = 1'b0;

    unique case (state_q)
      HZ_RUN, HZ_LU_STALL: begin
        state_d = HZ_RUN;
        if (WB_halt) begin
          state_d = HZ_HALTED;
        end else if (dmem_stall) begin
          state_d = HZ_MEM_WAIT;
          tmo_d   = TMO_W'(1);
        end else if (IE_branch_taken) begin
          {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (imem_stall) begin
          {ifid_we, idex_we, exmem_we, memwb_we} = '1;
          ifid_flush = 1'b1;
        end else if (lu_hazard && (state_q == HZ_RUN)) begin
          // The bubble occupies EX next cycle, so LU_STALL never re-detects.
          {idex_we, exmem_we, memwb_we} = '1;
          idex_bubble = 1'b1;
          state_d     = HZ_LU_STALL;
        end else begin
          {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '1;
        end
      end
      HZ_MEM_WAIT: begin
        if (!dmem_stall) begin
          {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '1;
          state_d = HZ_RUN;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LIMIT) begin
          err_d   = 1'b1;
          state_d = HZ_HALTED;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      HZ_HALTED: begin
        state_d = HZ_HALTED;
      end
      default: begin
        state_d = HZ_RUN;
      end
    endcase

    if (!rst_n) begin
      {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we} = '0;
    end
  end

  assign halted = (state_q == HZ_HALTED);
  assign err    = err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (CNT_W=2, MEM_TIMEOUT=3).
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ID_Instr;
  logic        ID_uses_rs, ID_uses_rt;
  logic        IE_memRead, IE_regWrite;
  logic [2:0]  IE_writereg;
  logic        IE_branch_taken, imem_stall, dmem_stall, WB_halt;
  logic        pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we;
  logic        halted, err;
  logic [1:0]  stall_cnt;

  int checks = 0;
  int fails  = 0;

  // {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we}
  localparam logic [6:0] C_RUN    = 7'b1101011;
  localparam logic [6:0] C_FREEZE = 7'b0000000;
  localparam logic [6:0] C_BRANCH = 7'b1111111;
  localparam logic [6:0] C_IMEM   = 7'b0111011;
  localparam logic [6:0] C_LU     = 7'b0001111;

  localparam logic [15:0] ADD_RS3 = 16'h0320;  // rs=3, rt=1
  localparam logic [15:0] ADD_RT3 = 16'h0560;  // rs=5, rt=3

  logic [6:0] ctl;
  assign ctl = {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(3)) dut (
    .clk(clk), .rst_n(rst_n), .ID_Instr(ID_Instr), .ID_uses_rs(ID_uses_rs),
    .ID_uses_rt(ID_uses_rt), .IE_memRead(IE_memRead), .IE_regWrite(IE_regWrite),
    .IE_writereg(IE_writereg), .IE_branch_taken(IE_branch_taken), .imem_stall(imem_stall),
    .dmem_stall(dmem_stall), .WB_halt(WB_halt), .pc_we(pc_we), .ifid_we(ifid_we),
    .ifid_flush(ifid_flush), .idex_we(idex_we), .idex_bubble(idex_bubble),
    .exmem_we(exmem_we), .memwb_we(memwb_we), .halted(halted), .err(err),
    .stall_cnt(stall_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ID_Instr = 16'h0; ID_uses_rs = 1'b0; ID_uses_rt = 1'b0;
    IE_memRead = 1'b0; IE_regWrite = 1'b0; IE_writereg = 3'd0;
    IE_branch_taken = 1'b0; imem_stall = 1'b0; dmem_stall = 1'b0; WB_halt = 1'b0;
  endtask

  task automatic load_use_r3;
    IE_memRead = 1'b1; IE_regWrite = 1'b1; IE_writereg = 3'd3;
    ID_Instr = ADD_RS3; ID_uses_rs = 1'b1; ID_uses_rt = 1'b1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    idle_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle_inputs();
    IE_branch_taken = 1'b1;
    #1;
    checks++; if (ctl !== C_FREEZE) begin fails++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_FREEZE); end
    tick(); tick();
    rst_n = 1'b1;
    IE_branch_taken = 1'b0;
    #1;
    checks++; if (halted !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL reset_flags got=%b%b exp=00", halted, err); end
    checks++; if (stall_cnt !== 2'd0) begin fails++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    checks++; if (ctl !== C_RUN) begin fails++; $display("FAIL reset_run got=%b exp=%b", ctl, C_RUN); end
  endtask

  task automatic test_load_use;
    apply_reset();
    load_use_r3();
    ID_uses_rt = 1'b0;
    #1;
    checks++; if (ctl !== C_LU) begin fails++; $display("FAIL lu_detect got=%b exp=%b", ctl, C_LU); end
    tick();
    checks++; if (stall_cnt !== 2'd1) begin fails++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
    checks++; if (ctl !== C_RUN) begin fails++; $display("FAIL lu_release got=%b exp=%b", ctl, C_RUN); end
    tick();
    checks++; if (stall_cnt !== 2'd1) begin fails++; $display("FAIL lu_cnt2 got=%0d exp=1", stall_cnt); end
    checks++; if (ctl !== C_LU) begin fails++; $display("FAIL lu_back_in_run got=%b exp=%b", ctl, C_LU); end
    idle_inputs();
  endtask

  task automatic test_no_false_stall;
    apply_reset();
    load_use_r3();
    ID_Instr = ADD_RT3; ID_uses_rt = 1'b0;
    #1;
    checks++; if (ctl !== C_RUN) begin fails++; $display("FAIL nfs_rt_unused got=%b exp=%b", ctl, C_RUN); end
    ID_uses_rt = 1'b1;
    #1;
    checks++; if (ctl !== C_LU) begin fails++; $display("FAIL nfs_rt_used got=%b exp=%b", ctl, C_LU); end
    ID_Instr = ADD_RS3; ID_uses_rt = 1'b0; IE_regWrite = 1'b0;
    #1;
    checks++; if (ctl !== C_RUN) begin fails++; $display("FAIL nfs_no_regwrite got=%b exp=%b", ctl, C_RUN); end
    IE_regWrite = 1'b1; IE_memRead = 1'b0;
    #1;
    checks++; if (ctl !== C_RUN) begin fails++; $display("FAIL nfs_no_load got=%b exp=%b", ctl, C_RUN); end
    IE_memRead = 1'b1; IE_writereg = 3'd2;
    #1;
    checks++; if (ctl !== C_RUN) begin fails++; $display("FAIL nfs_other_reg got=%b exp=%b", ctl, C_RUN); end
    tick();
    checks++; if (stall_cnt !== 2'd0) begin fails++; $display("FAIL nfs_cnt got=%0d exp=0", stall_cnt); end
    idle_inputs();
  endtask

  task automatic test_branch;
    apply_reset();
    load_use_r3();
    IE_branch_taken = 1'b1;
    #1;
    checks++; if (ctl !== C_BRANCH) begin fails++; $display("FAIL br_lu got=%b exp=%b", ctl, C_BRANCH); end
    imem_stall = 1'b1;
    #1;
    checks++; if (ctl !== C_BRANCH) begin fails++; $display("FAIL br_imem got=%b exp=%b", ctl, C_BRANCH); end
    tick();
    IE_branch_taken = 1'b0; imem_stall = 1'b0;
    #1;
    checks++; if (ctl !== C_LU) begin fails++; $display("FAIL br_no_lustall got=%b exp=%b", ctl, C_LU); end
    checks++; if (stall_cnt !== 2'd0) begin fails++; $display("FAIL br_cnt got=%0d exp=0", stall_cnt); end
    imem_stall = 1'b1;
    #1;
    checks++; if (ctl !== C_IMEM) begin fails++; $display("FAIL imem_over_lu got=%b exp=%b", ctl, C_IMEM); end
    idle_inputs();
    imem_stall = 1'b1;
    #1;
    checks++; if (ctl !== C_IMEM) begin fails++; $display("FAIL imem_only got=%b exp=%b", ctl, C_IMEM); end
    idle_inputs();
    tick();
  endtask

  task automatic test_mem_wait;
    apply_reset();
    dmem_stall = 1'b1; IE_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctl !== C_FREEZE) begin fails++; $display("FAIL memwait_frozen[%0d] got=%b exp=%b", i, ctl, C_FREEZE); end
      tick();
    end
    dmem_stall = 1'b0;
    #1;
    checks++; if (ctl !== C_RUN) begin fails++; $display("FAIL memwait_release got=%b exp=%b", ctl, C_RUN); end
    tick();
    checks++; if (ctl !== C_BRANCH) begin fails++; $display("FAIL memwait_held_branch got=%b exp=%b", ctl, C_BRANCH); end
    checks++; if (err !== 1'b0 || halted !== 1'b0) begin fails++; $display("FAIL memwait_flags got=%b%b exp=00", err, halted); end
    checks++; if (stall_cnt !== 2'd3) begin fails++; $display("FAIL memwait_cnt got=%0d exp=3", stall_cnt); end
    idle_inputs();
  endtask

  task automatic test_timeout;
    apply_reset();
    dmem_stall = 1'b1;
    tick(); tick(); tick();
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL tmo_early got=%b exp=0", err); end
    tick();
    checks++; if (err !== 1'b1 || halted !== 1'b1) begin fails++; $display("FAIL tmo_err got=%b%b exp=11", err, halted); end
    dmem_stall = 1'b0; IE_branch_taken = 1'b1; load_use_r3();
    #1;
    checks++; if (ctl !== C_FREEZE) begin fails++; $display("FAIL tmo_halt_ctl got=%b exp=%b", ctl, C_FREEZE); end
    tick();
    checks++; if (err !== 1'b1 || halted !== 1'b1) begin fails++; $display("FAIL tmo_sticky got=%b%b exp=11", err, halted); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle_inputs();
    #1;
    checks++; if (err !== 1'b0 || halted !== 1'b0 || stall_cnt !== 2'd0) begin
      fails++; $display("FAIL tmo_clear got=%b%b cnt=%0d exp=00 cnt=0", err, halted, stall_cnt); end
  endtask

  task automatic test_halt_reset;
    apply_reset();
    WB_halt = 1'b1; load_use_r3();
    #1;
    checks++; if (ctl !== C_FREEZE) begin fails++; $display("FAIL halt_ctl got=%b exp=%b", ctl, C_FREEZE); end
    tick();
    WB_halt = 1'b0; IE_branch_taken = 1'b1;
    checks++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_set got=%b exp=1", halted); end
    tick(); tick();
    checks++; if (halted !== 1'b1 || ctl !== C_FREEZE) begin fails++; $display("FAIL halt_sticky got=%b ctl=%b exp=1 ctl=%b", halted, ctl, C_FREEZE); end
    apply_reset();
    load_use_r3();
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (ctl !== C_FREEZE) begin fails++; $display("FAIL rst_in_lu_ctl got=%b exp=%b", ctl, C_FREEZE); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (stall_cnt !== 2'd0 || halted !== 1'b0) begin fails++; $display("FAIL rst_in_lu_state cnt=%0d halted=%b exp cnt=0 halted=0", stall_cnt, halted); end
    checks++; if (ctl !== C_LU) begin fails++; $display("FAIL rst_in_lu_run got=%b exp=%b", ctl, C_LU); end
    idle_inputs();
  endtask

  task automatic test_saturation;
    logic [1:0] exp_cnt;
    apply_reset();
    imem_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_cnt = (i < 3) ? 2'(i + 1) : 2'd3;
      checks++; if (stall_cnt !== exp_cnt) begin fails++; $display("FAIL sat[%0d] got=%0d exp=%0d", i, stall_cnt, exp_cnt); end
    end
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_halt_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
